// File: rtl/toy_cmd_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : toy_cmd_sequencer_if                                          |
// | Purpose  : Host word stream, result stream and operand-memory port       |
// |            bundle owned by the TOY command sequencer.                    |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
interface toy_cmd_sequencer_if #(
   parameter int ADDR_SIZE = 10,
   parameter int WORD_SIZE = 16
);
   // host -> sequencer word stream
   logic [WORD_SIZE-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   // sequencer -> host result stream
   logic [WORD_SIZE-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   // operand memory write port
   logic [ADDR_SIZE-1:0] w_addr;
   logic [WORD_SIZE-1:0] w_data;
   logic                 w_en;
   // result memory read port (data returns one cycle after address)
   logic [ADDR_SIZE-1:0] r_addr;
   logic [WORD_SIZE-1:0] mem_r_data;

   // sequencer side: owns the memory ports and both stream handshakes
   modport master (
      input  in_data, in_valid, out_ready, mem_r_data,
      output in_ready, out_data, out_valid, w_addr, w_data, w_en, r_addr
   );

   // environment side: SPI bridge plus memory
   modport slave (
      output in_data, in_valid, out_ready, mem_r_data,
      input  in_ready, out_data, out_valid, w_addr, w_data, w_en, r_addr
   );
endinterface
`default_nettype wire

// File: rtl/toy_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : toy_cmd_sequencer                                             |
// | Purpose  : Parses the 16-bit host word stream into CSR writes, operand   |
// |            loads, compute start/done and result readback.                |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module toy_cmd_sequencer #(
   parameter int                   ADDR_SIZE = 10,
   parameter int                   WORD_SIZE = 16,
   parameter logic [ADDR_SIZE-1:0] VEC_BASE  = 10'h000,
   parameter logic [ADDR_SIZE-1:0] MAT_BASE  = 10'h040,
   parameter logic [ADDR_SIZE-1:0] RES_BASE  = 10'h300,
   parameter int                   MAX_LEN   = 32
) (
   input  wire                  clk,
   input  wire                  reset_n,
   toy_cmd_sequencer_if.master  bus,
   output logic [5:0]           vec_len,
   output logic [5:0]           mat_rows,
   output logic                 start,
   input  wire                  done,
   output logic                 busy,
   output logic                 err
);

   localparam logic [3:0] OP_CSR   = 4'h1;
   localparam logic [3:0] OP_START = 4'h3;
   localparam logic [3:0] OP_LDVEC = 4'h4;
   localparam logic [3:0] OP_LDMAT = 4'h5;
   localparam logic [3:0] OP_READ  = 4'h6;

   localparam logic [3:0] IDX_VEC_LEN  = 4'd1;
   localparam logic [3:0] IDX_MAT_ROWS = 4'd2;

   localparam logic [WORD_SIZE-1:0] MAX_WORD = WORD_SIZE'(MAX_LEN);
   localparam logic [5:0]           MAX_CSR  = 6'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CSR_VAL  = 3'd1,
      S_LOAD_VEC = 3'd2,
      S_LOAD_MAT = 3'd3,
      S_RUN      = 3'd4,
      S_RD_ADDR  = 3'd5,
      S_RD_WAIT  = 3'd6,
      S_RD_OUT   = 3'd7
   } state_t;

   state_t               state;
   logic [11:0]          cnt;
   logic [11:0]          cnt_nxt;
   logic [3:0]           csr_idx;
   logic [3:0]           opcode;
   logic                 accept;
   logic                 csr_over;
   logic [5:0]           csr_val;
   logic [11:0]          vec_total;
   logic [11:0]          rows_total;
   logic [11:0]          mat_total;
   logic [11:0]          load_total;
   logic [ADDR_SIZE-1:0] load_base;

   assign opcode     = bus.in_data[WORD_SIZE-1 -: 4];
   assign accept     = bus.in_valid && bus.in_ready;
   assign cnt_nxt    = cnt + 12'd1;
   assign vec_total  = {6'd0, vec_len};
   assign rows_total = {6'd0, mat_rows};
   assign mat_total  = vec_total * rows_total;
   assign load_total = (state == S_LOAD_MAT) ? mat_total : vec_total;
   assign load_base  = (state == S_LOAD_MAT) ? MAT_BASE : VEC_BASE;

   // CSR values above the limit saturate to it
   assign csr_over = (bus.in_data > MAX_WORD);
   assign csr_val  = csr_over ? MAX_CSR : bus.in_data[5:0];

   assign busy = (state != S_IDLE);

   // Words are taken while parsing commands or load data. A load with a zero
   // element count holds in_ready low for its single cycle so that no host
   // word is swallowed while it falls back to IDLE.
   always_comb begin
      bus.in_ready = 1'b0;
      case (state)
         S_IDLE, S_CSR_VAL:     bus.in_ready = 1'b1;
         S_LOAD_VEC, S_LOAD_MAT: bus.in_ready = (load_total != 12'd0);
         default:               bus.in_ready = 1'b0;
      endcase
   end

   // Command FSM with registered memory, stream, CSR and start outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         cnt           <= '0;
         csr_idx       <= '0;
         vec_len       <= '0;
         mat_rows      <= '0;
         start         <= 1'b0;
         err           <= 1'b0;
         bus.w_en      <= 1'b0;
         bus.w_addr    <= '0;
         bus.w_data    <= '0;
         bus.r_addr    <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         bus.w_en <= 1'b0;
         start    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  cnt <= '0;
                  case (opcode)
                     OP_CSR: begin
                        csr_idx <= bus.in_data[3:0];
                        state   <= S_CSR_VAL;
                     end
                     OP_LDVEC: state <= S_LOAD_VEC;
                     OP_LDMAT: state <= S_LOAD_MAT;
                     OP_START: begin
                        start <= 1'b1;
                        state <= S_RUN;
                     end
                     OP_READ: begin
                        bus.r_addr <= RES_BASE;
                        state      <= S_RD_ADDR;
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end

            S_CSR_VAL: begin
               if (accept) begin
                  state <= S_IDLE;
                  if (csr_idx == IDX_VEC_LEN) begin
                     vec_len <= csr_val;
                     if (csr_over) err <= 1'b1;
                  end else if (csr_idx == IDX_MAT_ROWS) begin
                     mat_rows <= csr_val;
                     if (csr_over) err <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            S_LOAD_VEC, S_LOAD_MAT: begin
               if (load_total == 12'd0) begin
                  state <= S_IDLE;
               end else if (accept) begin
                  bus.w_en   <= 1'b1;
                  bus.w_addr <= load_base + ADDR_SIZE'(cnt);
                  bus.w_data <= bus.in_data;
                  cnt        <= cnt_nxt;
                  if (cnt_nxt == load_total) state <= S_IDLE;
               end
            end

            S_RUN: begin
               // the start cycle itself never sees done
               if (!start && done) state <= S_IDLE;
            end

            S_RD_ADDR: begin
               if (rows_total == 12'd0) state <= S_IDLE;
               else                     state <= S_RD_WAIT;
            end

            S_RD_WAIT: begin
               bus.out_data  <= bus.mem_r_data;
               bus.out_valid <= 1'b1;
               state         <= S_RD_OUT;
            end

            S_RD_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  cnt           <= cnt_nxt;
                  if (cnt_nxt == rows_total) begin
                     state <= S_IDLE;
                  end else begin
                     bus.r_addr <= RES_BASE + ADDR_SIZE'(cnt_nxt);
                     state      <= S_RD_ADDR;
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_toy_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module   : tb_toy_cmd_sequencer                                          |
// | Purpose  : Directed self-checking bench with a word-level reference      |
// |            model of the command sequencer.                               |
// | Revision : 1.0  initial release                                          |
// ----------------------------------------------------------------------------
module tb_toy_cmd_sequencer;

   localparam int         ADDR_SIZE = 10;
   localparam int         WORD_SIZE = 16;
   localparam logic [9:0] VEC_BASE  = 10'h000;
   localparam logic [9:0] MAT_BASE  = 10'h040;
   localparam logic [9:0] RES_BASE  = 10'h300;
   localparam int         MAX_LEN   = 32;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       done;
   logic [5:0] vec_len;
   logic [5:0] mat_rows;
   logic       start;
   logic       busy;
   logic       err;

   int checks   = 0;
   int failures = 0;

   toy_cmd_sequencer_if #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE)) bus ();

   toy_cmd_sequencer #(
      .ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE),
      .VEC_BASE(VEC_BASE), .MAT_BASE(MAT_BASE), .RES_BASE(RES_BASE),
      .MAX_LEN(MAX_LEN)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .vec_len(vec_len), .mat_rows(mat_rows), .start(start),
      .done(done), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // result memory: synchronous read, data one cycle after address
   logic [15:0] mem [0:1023];
   logic [15:0] rd_q;
   always @(posedge clk) rd_q <= mem[bus.r_addr];
   assign bus.mem_r_data = rd_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model (word-level interpretation) ----------
   int          m_mode;      // 0 command, 1 CSR value, 2 load data
   logic [3:0]  m_idx;
   logic [5:0]  m_vec, m_rows;
   logic        m_err;
   logic [9:0]  m_base;
   int          m_off, m_rem;
   int          exp_start;
   logic [25:0] exp_wr [$];
   logic [15:0] exp_rd [$];
   logic [25:0] wr_log [$];
   logic [25:0] e_wr;
   logic [15:0] e_rd;

   task automatic model_reset();
      m_mode = 0; m_idx = 0; m_vec = 0; m_rows = 0; m_err = 0;
      m_base = 0; m_off = 0; m_rem = 0; exp_start = 0;
      exp_wr.delete(); exp_rd.delete();
   endtask

   task automatic model_accept(input logic [15:0] w);
      logic [15:0] v;
      case (m_mode)
         0: begin
            case (w[15:12])
               4'h1: begin m_mode = 1; m_idx = w[3:0]; end
               4'h4: if (m_vec != 0) begin
                  m_mode = 2; m_base = VEC_BASE; m_off = 0; m_rem = int'(m_vec);
               end
               4'h5: if (int'(m_vec) * int'(m_rows) != 0) begin
                  m_mode = 2; m_base = MAT_BASE; m_off = 0; m_rem = int'(m_vec) * int'(m_rows);
               end
               4'h3: exp_start++;
               4'h6: for (int i = 0; i < int'(m_rows); i++) exp_rd.push_back(mem[RES_BASE + 10'(i)]);
               default: m_err = 1'b1;
            endcase
         end
         1: begin
            m_mode = 0;
            v = (w > 16'(MAX_LEN)) ? 16'(MAX_LEN) : w;
            if (m_idx == 4'd1 || m_idx == 4'd2) begin
               if (w > 16'(MAX_LEN)) m_err = 1'b1;
               if (m_idx == 4'd1) m_vec = v[5:0];
               else               m_rows = v[5:0];
            end else begin
               m_err = 1'b1;
            end
         end
         default: begin
            exp_wr.push_back({m_base + 10'(m_off), w});
            m_off++;
            m_rem--;
            if (m_rem == 0) m_mode = 0;
         end
      endcase
   endtask

   // compare process: every cycle, sampled just after the falling edge
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         #1;
         if (!reset_n) begin
            model_reset();
         end else begin
            check("vec_len", vec_len, m_vec);
            check("mat_rows", mat_rows, m_rows);
            check("err", err, m_err);
            if (bus.w_en) begin
               wr_log.push_back({bus.w_addr, bus.w_data});
               if (exp_wr.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_write actual=%h_%h required=none", bus.w_addr, bus.w_data);
               end else begin
                  e_wr = exp_wr.pop_front();
                  check("write", {bus.w_addr, bus.w_data}, e_wr);
               end
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_rd.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_read actual=%h required=none", bus.out_data);
               end else begin
                  e_rd = exp_rd.pop_front();
                  check("read_word", bus.out_data, e_rd);
               end
            end
            if (start) begin
               checks++;
               if (exp_start == 0) begin
                  failures++;
                  $display("FAIL unexpected_start actual=1 required=0");
               end else begin
                  exp_start--;
               end
            end
            if (bus.in_valid && bus.in_ready) model_accept(bus.in_data);
         end
      end
   end

   // ---------------- stimulus ---------------------------------------------
   task automatic send(input logic [15:0] w, output int waited);
      waited = 0;
      bus.in_data  = w;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=in_ready_low required=accept word=%h", w);
         bus.in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   logic [15:0] vec_words [3] = '{16'h0012, 16'h0035, 16'h002a};
   logic [15:0] mat_words [6] = '{16'h0031, 16'h0050, 16'h0001, 16'h0012, 16'h000a, 16'h0002};

   initial begin
      int wt;
      int n;
      reset_n       = 1'b0;
      done          = 1'b0;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[RES_BASE]         = 16'h00AA;
      mem[RES_BASE + 10'd1] = 16'h00BB;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_w_en", bus.w_en, 0);
      check("rst_w_addr", bus.w_addr, 0);
      check("rst_w_data", bus.w_data, 0);
      check("rst_r_addr", bus.r_addr, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_vec_len", vec_len, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);

      // zero-length vector load falls straight back to IDLE
      send(16'h4000, wt);
      check("zero_len_busy", busy, 1);
      @(negedge clk);
      check("zero_len_idle", busy, 0);

      // CSR writes
      send(16'h1001, wt); send(16'h0003, wt);
      send(16'h1002, wt); send(16'h0002, wt);
      check("csr_vec_len_lit", vec_len, 3);
      check("csr_mat_rows_lit", mat_rows, 2);
      check("csr_err_lit", err, 0);

      // vector load, back to back
      send(16'h4000, wt);
      for (int i = 0; i < 3; i++) begin
         send(vec_words[i], wt);
         check("vec_in_ready_stall", wt, 0);
      end
      check("vec_done_idle", busy, 0);
      @(negedge clk);
      check("vec_write_count", wr_log.size(), 3);
      for (int i = 0; i < 3 && i < wr_log.size(); i++)
         check("vec_write_lit", wr_log[i], {10'h000 + 10'(i), vec_words[i]});

      // matrix load 3x2, then the next word is a command
      send(16'h5000, wt);
      for (int i = 0; i < 6; i++) send(mat_words[i], wt);
      send(16'h1002, wt); send(16'h0002, wt);
      @(negedge clk);
      check("mat_write_count", wr_log.size(), 9);
      for (int i = 0; i < 6 && i + 3 < wr_log.size(); i++)
         check("mat_write_lit", wr_log[i + 3], {10'h040 + 10'(i), mat_words[i]});
      check("mat_rows_after", mat_rows, 2);
      check("mat_busy_after", busy, 0);

      // start / done
      send(16'h3000, wt);
      check("start_pulse", start, 1);
      check("run_busy", busy, 1);
      check("run_in_ready", bus.in_ready, 0);
      done         = 1'b1;              // during the start cycle: ignored
      bus.in_data  = 16'h4000;          // offered during RUN, must not be taken
      bus.in_valid = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("start_one_cycle", start, 0);
      check("done_in_start_ignored", busy, 1);
      repeat (8) begin
         @(negedge clk);
         check("run_hold_in_ready", bus.in_ready, 0);
         check("run_hold_busy", busy, 1);
      end
      bus.in_valid = 1'b0;
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("run_done_idle", busy, 0);

      // readback with backpressure
      bus.out_ready = 1'b0;
      send(16'h6000, wt);
      n = 0;
      while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
      check("rd_latency", n, 2);
      check("rd_first_valid", bus.out_valid, 1);
      check("rd_first_data", bus.out_data, 16'h00AA);
      check("rd_in_ready", bus.in_ready, 0);
      repeat (3) begin
         @(negedge clk);
         check("rd_hold_valid", bus.out_valid, 1);
         check("rd_hold_data", bus.out_data, 16'h00AA);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      n = 0;
      while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
      check("rd_second_valid", bus.out_valid, 1);
      check("rd_second_data", bus.out_data, 16'h00BB);
      @(negedge clk);
      check("rd_done_idle", busy, 0);
      check("rd_done_valid", bus.out_valid, 0);

      // errors
      send(16'h7000, wt);
      check("bad_op_err", err, 1);
      check("bad_op_idle", busy, 0);
      send(16'h1001, wt); send(16'h0040, wt);
      check("sat_vec_len", vec_len, 32);
      check("sat_err", err, 1);

      // reset in the middle of a matrix load
      send(16'h5000, wt);
      send(16'h1111, wt); send(16'h2222, wt);
      reset_n = 1'b0;
      #1;
      check("abort_w_en", bus.w_en, 0);
      check("abort_busy", busy, 0);
      check("abort_err", err, 0);
      check("abort_vec_len", vec_len, 0);
      check("abort_out_valid", bus.out_valid, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      send(16'h1001, wt); send(16'h0001, wt);
      check("post_rst_vec_len", vec_len, 1);
      check("post_rst_err", err, 0);
      check("post_rst_busy", busy, 0);

      repeat (2) @(negedge clk);
      check("pending_writes", exp_wr.size(), 0);
      check("pending_reads", exp_rd.size(), 0);
      check("pending_start", exp_start, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
